// File: rtl/vga_pixel_pipe.sv
// Pixel back end: frame-buffer fetch, palette lookup to RGB, sync/blank alignment, frame counter.
// Define VGA_PAL_SYNC_EN to hold palette writes in a shadow register until the next vsync fall.
module vga_pixel_pipe #(
    parameter int ADDR_W  = 19,
    parameter int PIX_W   = 1,
    parameter int COLOR_W = 10,
    parameter int RAM_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    in_mem_add,
    input  logic                 in_hsync,
    input  logic                 in_vsync,
    input  logic                 in_blank,
    output logic [ADDR_W-1:0]    fb_rd_add,
    input  logic [PIX_W-1:0]     fb_rd_data,
    input  logic                 pal_wr_valid,
    input  logic [PIX_W-1:0]     pal_wr_index,
    input  logic [3*COLOR_W-1:0] pal_wr_rgb,
    output logic                 pal_wr_ready,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic                 vga_blank,
    output logic [15:0]          frame_count
);
    localparam int L     = RAM_LAT + 2;
    localparam int NPAL  = 1 << PIX_W;
    localparam int RGB_W = 3 * COLOR_W;

    logic [ADDR_W-1:0] fb_rd_add_q;
    logic [L-1:0]      hs_pipe_q, vs_pipe_q, bl_pipe_q;
    logic [RGB_W-1:0]  pal_q [NPAL];
    logic [RGB_W-1:0]  rgb_q;
    logic              vs_prev_q;
    logic              vs_fall;
    logic [15:0]       frame_cnt_q;
    logic              pal_we;
    logic [PIX_W-1:0]  pal_widx;
    logic [RGB_W-1:0]  pal_wrgb;

    // Address only advances during active video so blanking never issues new reads.
    always_ff @(posedge clock) begin
        if (reset)         fb_rd_add_q <= '0;
        else if (in_blank) fb_rd_add_q <= in_mem_add;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
            bl_pipe_q <= '0;
        end else begin
            hs_pipe_q <= {hs_pipe_q[L-2:0], in_hsync};
            vs_pipe_q <= {vs_pipe_q[L-2:0], in_vsync};
            bl_pipe_q <= {bl_pipe_q[L-2:0], in_blank};
        end
    end

    // Stage L-2 holds the blank that lands on the output together with this lookup.
    always_ff @(posedge clock) begin
        if (reset)                rgb_q <= '0;
        else if (bl_pipe_q[L-2])  rgb_q <= pal_q[fb_rd_data];
        else                      rgb_q <= '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NPAL; i++)
                pal_q[i] <= (i == NPAL-1) ? {RGB_W{1'b1}} : {RGB_W{1'b0}};
        end else if (pal_we) begin
            pal_q[pal_widx] <= pal_wrgb;
        end
    end

    assign vs_fall = vs_prev_q & ~in_vsync;

    always_ff @(posedge clock) begin
        if (reset) begin
            vs_prev_q   <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            vs_prev_q <= in_vsync;
            if (vs_fall) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

`ifdef VGA_PAL_SYNC_EN
    typedef enum logic [1:0] {PAL_EMPTY, PAL_PENDING, PAL_COMMIT} pal_st_e;
    pal_st_e          st_q, st_d;
    logic [PIX_W-1:0] sh_idx_q;
    logic [RGB_W-1:0] sh_rgb_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q     <= PAL_EMPTY;
            sh_idx_q <= '0;
            sh_rgb_q <= '0;
        end else begin
            st_q <= st_d;
            if (pal_wr_valid && pal_wr_ready) begin
                sh_idx_q <= pal_wr_index;
                sh_rgb_q <= pal_wr_rgb;
            end
        end
    end

    // Commit lands one cycle after vs_fall, deep inside vertical blanking.
    always_comb begin
        st_d         = st_q;
        pal_wr_ready = 1'b0;
        pal_we       = 1'b0;
        case (st_q)
            PAL_EMPTY: begin
                pal_wr_ready = !reset;
                if (pal_wr_valid && !reset) st_d = PAL_PENDING;
            end
            PAL_PENDING: if (vs_fall) st_d = PAL_COMMIT;
            PAL_COMMIT: begin
                pal_we = 1'b1;
                st_d   = PAL_EMPTY;
            end
            default: st_d = PAL_EMPTY;
        endcase
    end

    assign pal_widx = sh_idx_q;
    assign pal_wrgb = sh_rgb_q;
`else
    assign pal_wr_ready = !reset;
    assign pal_we       = pal_wr_valid & pal_wr_ready;
    assign pal_widx     = pal_wr_index;
    assign pal_wrgb     = pal_wr_rgb;
`endif

    assign fb_rd_add   = fb_rd_add_q;
    assign vga_r       = rgb_q[RGB_W-1 -: COLOR_W];
    assign vga_g       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga_b       = rgb_q[COLOR_W-1:0];
    assign vga_hsync   = hs_pipe_q[L-1];
    assign vga_vsync   = vs_pipe_q[L-1];
    assign vga_blank   = bl_pipe_q[L-1];
    assign frame_count = frame_cnt_q;

endmodule
